ddr3_rd_arbiter: RTL
====================

Name: ddr3_rd_arbiter

Overview:
- Shares the single DDR3 burst reader (`ddr3_rd_control`) between N_REQ read clients, for example the fill-readout command SM and a debug/circular-buffer dump SM.
- Grants are round-robin. The granted client's start address and burst count are latched, `enable_reading` is held for the transaction, and the async `reading_done` is synchronized.
- The reader is released only after the client drops its request and `reading_done` clears.
- Includes a watchdog timeout so a hung reader cannot lock out other clients.

Parameters:
- N_REQ, 2, number of requesting clients (2..8).
- TIMEOUT_W, 28, width of the watchdog counter.
- TIMEOUT_CYCLES, 28'd200_000_000, cycles allowed in WAIT_DONE before abort.

Ports:
- clk  in  1  local clock
- reset  in  1  synchronous, active-high
- req  in  N_REQ  level request per client; held until that client has consumed all data
- req_start_addr  in  N_REQ*23  packed per-client first 128-bit burst address; client i at [i*23+:23]
- req_burst_cnt  in  N_REQ*24  packed per-client burst count; client i at [i*24+:24]
- grant  out  N_REQ  one-hot; the client that owns the reader
- done  out  N_REQ  one-cycle pulse to the owner when `reading_done` is seen, or on abort
- timeout_err  out  1  one-cycle pulse accompanying `done` on watchdog abort
- ddr3_rd_start_addr  out  23  to reader
- ddr3_rd_burst_cnt  out  24  to reader
- enable_reading  out  1  level; starts the reader
- reading_done  in  1  from reader, asynchronous; 2-flop synchronized internally (ASYNC_REG)
- busy  out  1  high in any state other than IDLE

Behaviour:
- **Reset:** all outputs 0, state IDLE, round-robin pointer = 0, watchdog = 0.
- **One-hot state machine, 6 states:**
  - IDLE: if any `req` bit is set, go to ARB.
  - ARB (1 cycle):
    - Select the first set `req` bit at or after `pointer`, wrapping modulo N_REQ.
    - Latch that client's address and count into `ddr3_rd_start_addr`/`ddr3_rd_burst_cnt`.
    - Assert `grant[i]`; set `pointer` to (i+1) mod N_REQ.
    - If no `req` bit is still set (requester withdrew), return to IDLE with no grant.
  - LOAD (1 cycle):
    - If the latched count == 0: pulse `done[i]` and go to DRAIN; `enable_reading` is never asserted.
    - Otherwise assert `enable_reading`, clear the watchdog, go to WAIT_DONE.
  - WAIT_DONE:
    - Hold `enable_reading` and `grant`; increment the watchdog each cycle.
    - On `reading_done_sync2` = 1: pulse `done[i]`, go to DRAIN.
    - If the watchdog reaches TIMEOUT_CYCLES-1: pulse `done[i]` and `timeout_err`, drop `enable_reading`, go to CLEAR.
  - DRAIN:
    - Hold `enable_reading` (unless already dropped by the zero-count path) and `grant`.
    - On `req[i]` = 0: drop `enable_reading` and `grant`, go to CLEAR.
  - CLEAR:
    - `grant` = 0, `enable_reading` = 0.
    - Wait for `reading_done_sync2` = 0, then go to IDLE; the earliest re-grant is the cycle after.
- **Latency:** `req` rising in IDLE → `grant` high 2 clocks later → `enable_reading` 3 clocks later.
- **Interface rules:**
  - `grant` is one-hot or zero at all times.
  - `ddr3_rd_*` is stable while `enable_reading` = 1.
  - Changes on non-granted `req` lines or on the granted client's address/count inputs after ARB are ignored.
- **Fairness:** with all clients requesting continuously, grants rotate 0,1,...,N_REQ-1,0.
- **Watchdog:** saturates, no wrap. `done` and `timeout_err` never fire in the same cycle for different clients.
- **Reset mid-transaction:** next edge returns to IDLE, `enable_reading` = 0, `grant` = 0. Stale `reading_done` is handled by CLEAR on the next transaction.

Decomposition:
- Shared package (ddr3_rd_arb_pkg):
  - State index constants IDLE..CLEAR.
  - ADDR_W = 23, BCNT_W = 24.
  - Default TIMEOUT_CYCLES.
- One natural sub-module: rr_pick.
  - Combinational round-robin priority select.
  - Inputs: `req` and `pointer`. Outputs: one-hot grant and binary index.
  - Reusable elsewhere.
- The synchronizer stays inline.

Test Plan:
- Single client: client 0, addr 23'h000400, count 24'd16; reader model raises `reading_done` 40 clocks after enable.
  - Required: `grant` = 01 2 clocks after `req`.
  - Required: `enable_reading` held with stable addr/count.
  - Required: `done[0]` pulses once.
  - Required: after `req[0]` drops, `enable_reading` falls, then `busy` falls after `reading_done` clears.
- Contention: `req` = 11 asserted in the same cycle.
  - Required: client 0 served first, then client 1.
  - Required: if `req` = 11 persists, the third grant goes to 0; no overlap of grants.
- Zero burst count: client 1, count 0.
  - Required: `done[1]` in LOAD, `enable_reading` never asserted, reader model sees no transaction.
- Timeout: TIMEOUT_CYCLES = 100, reader never asserts done.
  - Required: `done[0]` and `timeout_err` pulse exactly 100 cycles after WAIT_DONE entry.
  - Required: `enable_reading` drops, and the next client is granted.
- Reset: assert reset during WAIT_DONE.
  - Required: all outputs 0 on the next clock.
  - Required: the subsequent request is granted normally.
- Stale done: `reading_done` held high for 10 cycles after a release.
  - Required: no new grant until it is low; the next transaction's `done` is not premature.

Source files
------------

// File: rtl/ddr3_rd_arb_pkg.sv
// Shared types and constants for the DDR3 burst-reader arbiter.
package ddr3_rd_arb_pkg;

  localparam int ADDR_W = 23;
  localparam int BCNT_W = 24;
  localparam logic [27:0] DEF_TIMEOUT_CYCLES = 28'd200_000_000;

  typedef enum logic [5:0] {
    IDLE      = 6'b000001,
    ARB       = 6'b000010,
    LOAD      = 6'b000100,
    WAIT_DONE = 6'b001000,
    DRAIN     = 6'b010000,
    CLEAR     = 6'b100000
  } arb_state_t;

endpackage

// File: rtl/ddr3_rd_arbiter_rr_pick.sv
// Combinational round-robin select: first set req bit at or after pointer, wrapping.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] pointer,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // Rotating a doubled copy keeps the search indices constant after unrolling.
  always_comb begin
    int unsigned j;
    logic [2*N-1:0] dbl;
    dbl   = {req, req} >> pointer;
    valid = 1'b0;
    j     = 0;
    idx   = '0;
    grant = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!valid && dbl[k]) begin
        valid = 1'b1;
        j     = 32'(pointer) + k;
      end
    end
    if (j >= N) j = j - N;
    if (valid) begin
      idx        = IW'(j);
      grant[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/ddr3_rd_arbiter.sv
// Round-robin arbiter sharing one DDR3 burst reader between N_REQ read clients.
module ddr3_rd_arbiter
  import ddr3_rd_arb_pkg::*;
#(
  parameter int                   N_REQ          = 2,
  parameter int                   TIMEOUT_W      = 28,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = TIMEOUT_W'(DEF_TIMEOUT_CYCLES)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*ADDR_W-1:0]   req_start_addr,
  input  logic [N_REQ*BCNT_W-1:0]   req_burst_cnt,
  output logic [N_REQ-1:0]          grant,
  output logic [N_REQ-1:0]          done,
  output logic                      timeout_err,
  output logic [ADDR_W-1:0]         ddr3_rd_start_addr,
  output logic [BCNT_W-1:0]         ddr3_rd_burst_cnt,
  output logic                      enable_reading,
  input  logic                      reading_done,
  output logic                      busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t state, state_n;
  logic [N_REQ-1:0]     grant_n, done_n, pick_oh;
  logic [PW-1:0]        ptr, ptr_n, pick_idx;
  logic                 pick_valid, terr_n, en_n;
  logic [ADDR_W-1:0]    addr_n;
  logic [BCNT_W-1:0]    cnt_n;
  logic [TIMEOUT_W-1:0] wdog, wdog_n;

  (* ASYNC_REG = "TRUE" *) logic reading_done_sync1;
  (* ASYNC_REG = "TRUE" *) logic reading_done_sync2;

  rr_pick #(.N(N_REQ), .IW(PW)) u_pick (
    .req    (req),
    .pointer(ptr),
    .grant  (pick_oh),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= IDLE;
      ptr                 <= '0;
      wdog                <= '0;
      grant               <= '0;
      done                <= '0;
      timeout_err         <= 1'b0;
      enable_reading      <= 1'b0;
      ddr3_rd_start_addr  <= '0;
      ddr3_rd_burst_cnt   <= '0;
      reading_done_sync1  <= 1'b0;
      reading_done_sync2  <= 1'b0;
    end else begin
      state               <= state_n;
      ptr                 <= ptr_n;
      wdog                <= wdog_n;
      grant               <= grant_n;
      done                <= done_n;
      timeout_err         <= terr_n;
      enable_reading      <= en_n;
      ddr3_rd_start_addr  <= addr_n;
      ddr3_rd_burst_cnt   <= cnt_n;
      reading_done_sync1  <= reading_done;
      reading_done_sync2  <= reading_done_sync1;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    wdog_n  = wdog;
    grant_n = grant;
    done_n  = '0;
    terr_n  = 1'b0;
    en_n    = enable_reading;
    addr_n  = ddr3_rd_start_addr;
    cnt_n   = ddr3_rd_burst_cnt;
    unique case (state)
      IDLE: if (|req) state_n = ARB;
      ARB: begin
        if (pick_valid) begin
          grant_n = pick_oh;
          addr_n  = req_start_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
          cnt_n   = req_burst_cnt[int'(pick_idx)*BCNT_W +: BCNT_W];
          ptr_n   = (int'(pick_idx) == N_REQ-1) ? '0 : pick_idx + 1'b1;
          state_n = LOAD;
        end else begin
          state_n = IDLE;
        end
      end
      LOAD: begin
        if (ddr3_rd_burst_cnt == '0) begin
          done_n  = grant;
          state_n = DRAIN;
        end else begin
          en_n    = 1'b1;
          wdog_n  = '0;
          state_n = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (wdog != '1) wdog_n = wdog + 1'b1;
        if (reading_done_sync2) begin
          done_n  = grant;
          state_n = DRAIN;
        end else if (wdog == TIMEOUT_CYCLES - 1'b1) begin
          done_n  = grant;
          terr_n  = 1'b1;
          en_n    = 1'b0;
          grant_n = '0;
          state_n = CLEAR;
        end
      end
      DRAIN: begin
        if ((req & grant) == '0) begin
          en_n    = 1'b0;
          grant_n = '0;
          state_n = CLEAR;
        end
      end
      CLEAR: begin
        grant_n = '0;
        en_n    = 1'b0;
        if (!reading_done_sync2) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
